// File: rtl/sprite_engine_if.sv
// Host register bus and video timing for sprite_engine.
// The host/video side uses the master modport, the sprite engine uses the slave modport.
interface sprite_engine_if #(
  parameter int POS_WIDTH   = 10,
  parameter int COLOR_WIDTH = 7
);
  // Register access
  logic                   enable;
  logic                   write_enable;
  logic [5:0]             address;
  logic [7:0]             data_in;
  logic [7:0]             data_out;
  // Video timing and pixel output
  logic [POS_WIDTH-1:0]   hpos;
  logic                   pixel_en;
  logic                   line_start;
  logic [COLOR_WIDTH-1:0] color_bg;
  logic [COLOR_WIDTH-1:0] color;
  logic                   collision_irq;

  modport master (
    output enable, write_enable, address, data_in,
    output hpos, pixel_en, line_start, color_bg,
    input  data_out, color, collision_irq
  );

  modport slave (
    input  enable, write_enable, address, data_in,
    input  hpos, pixel_en, line_start, color_bg,
    output data_out, color, collision_irq
  );
endinterface

// File: rtl/sprite_engine.sv
// Sprite engine: NUM_OBJ hardware sprite channels, each shifting out a graphic
// line at its X position, composited by priority (lowest index wins) onto the
// background colour.
// Register map: obj*8+r (r0 posx lo, r1 posx hi, r2 graphic shadow, r3 colour
// in data_in[7:1], r4 control {scale[3:2], reflect[1], enable[0]}); 0x38 collision
// status (write-1-to-clear), 0x39 irq mask.
// Optional feature macro: SPRITE_ENGINE_COLLISION_EN adds collision detection,
// status/mask registers and collision_irq; without it they read 0 and irq is 0.
// Supported ranges: POS_WIDTH 9..16, DATA_WIDTH 1..8, COLOR_WIDTH 1..7.
module sprite_engine #(
  parameter int NUM_OBJ     = 4,
  parameter int POS_WIDTH   = 10,
  parameter int DATA_WIDTH  = 8,
  parameter int COLOR_WIDTH = 7
) (
  input logic            raw_clk,
  input logic            reset,
  sprite_engine_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT, DONE} state_t;

  localparam int IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  // Index 7 decodes to the global registers, so at most 7 objects are programmable.
  localparam int NUM_PROG = (NUM_OBJ > 7) ? 7 : NUM_OBJ;

  // Host-visible configuration
  logic [POS_WIDTH-1:0]   posx      [NUM_OBJ];
  logic [DATA_WIDTH-1:0]  shadow    [NUM_OBJ];
  logic [COLOR_WIDTH-1:0] obj_color [NUM_OBJ];
  logic [1:0]             obj_scale [NUM_OBJ];
  logic [NUM_OBJ-1:0]     obj_en;
  logic [NUM_OBJ-1:0]     obj_ref;

  // Per-line copies so host writes mid-line only affect the next line
  logic [DATA_WIDTH-1:0]  act_gfx   [NUM_OBJ];
  logic [POS_WIDTH-1:0]   act_posx  [NUM_OBJ];
  logic [1:0]             act_scale [NUM_OBJ];
  logic [NUM_OBJ-1:0]     act_ref;

  state_t                 state       [NUM_OBJ];
  state_t                 state_nxt   [NUM_OBJ];
  logic [IDX_W-1:0]       bit_idx     [NUM_OBJ];
  logic [IDX_W-1:0]       bit_idx_nxt [NUM_OBJ];
  logic [1:0]             hold_cnt    [NUM_OBJ];
  logic [1:0]             hold_cnt_nxt[NUM_OBJ];
  logic [NUM_OBJ-1:0]     emit;     // object occupies a bit slot this pixel
  logic [NUM_OBJ-1:0]     obj_bit;  // object paints this pixel

  logic [NUM_OBJ-1:0]     status;
  logic [NUM_OBJ-1:0]     mask;
  logic [7:0]             rd_data;
  logic [COLOR_WIDTH-1:0] win_color;

  logic [2:0] sel_obj;
  logic [2:0] sel_reg;
  logic       is_global;
  logic       obj_hit;

  assign sel_obj   = bus.address[5:3];
  assign sel_reg   = bus.address[2:0];
  assign is_global = (sel_obj == 3'd7);
  assign obj_hit   = (int'(sel_obj) < NUM_PROG);

  // Last hold count for a bit slot: 1, 2 or 4 pixels per bit
  function automatic logic [1:0] hold_last(input logic [1:0] scale);
    case (scale)
      2'd0:    return 2'd0;
      2'd1:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // Host writes to per-object configuration
  // NOTE: the configuration arrays are a handful of flops, not a RAM, so they
  // take the asynchronous reset like any other state.
  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        posx[i]      <= '0;
        shadow[i]    <= '0;
        obj_color[i] <= '0;
        obj_scale[i] <= '0;
      end
      obj_en  <= '0;
      obj_ref <= '0;
    end else if (bus.write_enable && obj_hit) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        if (int'(sel_obj) == i) begin
          case (sel_reg)
            3'd0: posx[i][7:0]           <= bus.data_in;
            3'd1: posx[i][POS_WIDTH-1:8] <= bus.data_in[POS_WIDTH-9:0];
            3'd2: shadow[i]              <= bus.data_in[DATA_WIDTH-1:0];
            3'd3: obj_color[i]           <= bus.data_in[COLOR_WIDTH:1];
            3'd4: begin
              obj_en[i]    <= bus.data_in[0];
              obj_ref[i]   <= bus.data_in[1];
              obj_scale[i] <= bus.data_in[3:2];
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Read mux: unmapped addresses and absent objects read as zero
  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    rd_data = '0;
    if (obj_hit) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        if (int'(sel_obj) == i) begin
          case (sel_reg)
            3'd0: rd_data                  = posx[i][7:0];
            3'd1: rd_data[POS_WIDTH-9:0]   = posx[i][POS_WIDTH-1:8];
            3'd2: rd_data[DATA_WIDTH-1:0]  = shadow[i];
            3'd3: rd_data[COLOR_WIDTH:1]   = obj_color[i];
            3'd4: rd_data[3:0]             = {obj_scale[i], obj_ref[i], obj_en[i]};
            default: ;
          endcase
        end
      end
    end else if (is_global) begin
      case (sel_reg)
        3'd0:    rd_data[NUM_OBJ-1:0] = status;
        3'd1:    rd_data[NUM_OBJ-1:0] = mask;
        default: ;
      endcase
    end
  end

  // Registered read data, loaded only on a read strobe
  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      bus.data_out <= '0;
    end else if (bus.enable && !bus.write_enable) begin
      bus.data_out <= rd_data;
    end
  end

  // Object FSM next state, bit slot advance and pixel emission
  always_comb begin
    for (int i = 0; i < NUM_OBJ; i++) begin
      state_nxt[i]    = state[i];
      bit_idx_nxt[i]  = bit_idx[i];
      hold_cnt_nxt[i] = hold_cnt[i];
      emit[i]         = 1'b0;
      obj_bit[i]      = 1'b0;

      case (state[i])
        ARMED:   emit[i] = bus.pixel_en && !bus.line_start && (bus.hpos == act_posx[i]);
        SHIFT:   emit[i] = bus.pixel_en && !bus.line_start;
        default: emit[i] = 1'b0;
      endcase

      if (emit[i]) begin
        obj_bit[i] = obj_en[i] && (act_ref[i] ? act_gfx[i][bit_idx[i]]
                                              : act_gfx[i][IDX_W'(DATA_WIDTH - 1) - bit_idx[i]]);
        state_nxt[i] = SHIFT;
        if (hold_cnt[i] == hold_last(act_scale[i])) begin
          hold_cnt_nxt[i] = '0;
          if (bit_idx[i] == IDX_W'(DATA_WIDTH - 1)) begin
            state_nxt[i] = DONE;
          end else begin
            bit_idx_nxt[i] = bit_idx[i] + 1'b1;
          end
        end else begin
          hold_cnt_nxt[i] = hold_cnt[i] + 1'b1;
        end
      end

      if (bus.line_start) begin
        state_nxt[i]    = obj_en[i] ? ARMED : IDLE;
        bit_idx_nxt[i]  = '0;
        hold_cnt_nxt[i] = '0;
      end
    end
  end

  // Object FSM state and per-line copies captured at line_start
  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        state[i]     <= IDLE;
        bit_idx[i]   <= '0;
        hold_cnt[i]  <= '0;
        act_gfx[i]   <= '0;
        act_posx[i]  <= '0;
        act_scale[i] <= '0;
      end
      act_ref <= '0;
    end else begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        state[i]    <= state_nxt[i];
        bit_idx[i]  <= bit_idx_nxt[i];
        hold_cnt[i] <= hold_cnt_nxt[i];
        if (bus.line_start) begin
          act_gfx[i]   <= shadow[i];
          act_posx[i]  <= posx[i];
          act_scale[i] <= obj_scale[i];
        end
      end
      if (bus.line_start) act_ref <= obj_ref;
    end
  end

  // Priority composite: lowest-indexed painting object wins over background
  always_comb begin
    win_color = bus.color_bg;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (obj_bit[i]) win_color = obj_color[i];
    end
  end

  // Output pixel register, advanced on pixel_en
  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      bus.color <= '0;
    end else if (bus.pixel_en) begin
      bus.color <= win_color;
    end
  end

`ifdef SPRITE_ENGINE_COLLISION_EN
  logic [NUM_OBJ-1:0] coll_set;
  logic [NUM_OBJ-1:0] status_clr;

  // Every painting object collides when at least two paint the same pixel
  assign coll_set   = ((obj_bit & (obj_bit - 1'b1)) != '0) ? obj_bit : '0;
  assign status_clr = (bus.write_enable && is_global && sel_reg == 3'd0)
                      ? bus.data_in[NUM_OBJ-1:0] : '0;

  // Sticky collision status (set beats clear) and interrupt mask
  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      status <= '0;
      mask   <= '0;
    end else begin
      status <= (status & ~status_clr) | coll_set;
      if (bus.write_enable && is_global && sel_reg == 3'd1) mask <= bus.data_in[NUM_OBJ-1:0];
    end
  end

  assign bus.collision_irq = |(status & mask);
`else
  assign status            = '0;
  assign mask              = '0;
  assign bus.collision_irq = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_engine.sv
// Self-checking bench for sprite_engine: directed scenarios with literal
// expectations plus randomized lines compared every cycle against a
// behavioural model of the register file, per-line sprite output and collisions.
module tb_sprite_engine;
  localparam int NUM_OBJ     = 4;
  localparam int POS_WIDTH   = 10;
  localparam int DATA_WIDTH  = 8;
  localparam int COLOR_WIDTH = 7;
`ifdef SPRITE_ENGINE_COLLISION_EN
  localparam bit COLL = 1'b1;
`else
  localparam bit COLL = 1'b0;
`endif

  logic raw_clk = 1'b0;
  logic reset;

  sprite_engine_if #(.POS_WIDTH(POS_WIDTH), .COLOR_WIDTH(COLOR_WIDTH)) bus ();

  sprite_engine #(
    .NUM_OBJ(NUM_OBJ), .POS_WIDTH(POS_WIDTH),
    .DATA_WIDTH(DATA_WIDTH), .COLOR_WIDTH(COLOR_WIDTH)
  ) dut (
    .raw_clk(raw_clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 raw_clk = ~raw_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_posx [NUM_OBJ];
  int m_gfx  [NUM_OBJ];
  int m_col  [NUM_OBJ];
  int m_scale[NUM_OBJ];
  bit m_en   [NUM_OBJ];
  bit m_ref  [NUM_OBJ];
  int m_status, m_mask, m_clr;
  // line state: k = pixels since the sprite started, -1 = not started
  int l_gfx [NUM_OBJ];
  int l_pos [NUM_OBJ];
  int l_hold[NUM_OBJ];
  bit l_ref [NUM_OBJ];
  bit l_armed[NUM_OBJ];
  int l_k   [NUM_OBJ];
  int e_color, e_dout;

  function automatic int mread(input int a);
    int o = a / 8;
    int r = a % 8;
    if (o == 7) return (r == 0) ? m_status : (r == 1) ? m_mask : 0;
    if (o >= NUM_OBJ) return 0;
    case (r)
      0: return m_posx[o] % 256;
      1: return m_posx[o] / 256;
      2: return m_gfx[o];
      3: return m_col[o] * 2;
      4: return m_scale[o] * 4 + (m_ref[o] ? 2 : 0) + (m_en[o] ? 1 : 0);
      default: return 0;
    endcase
  endfunction

  task automatic mwrite(input int a, input int d);
    int o = a / 8;
    int r = a % 8;
    if (o == 7) begin
      if (r == 0) m_clr = d % 16;
      if (r == 1 && COLL) m_mask = d % 16;
    end else if (o < NUM_OBJ) begin
      case (r)
        0: m_posx[o] = (m_posx[o] / 256) * 256 + d;
        1: m_posx[o] = (d % 4) * 256 + m_posx[o] % 256;
        2: m_gfx[o] = d;
        3: m_col[o] = d / 2;
        4: begin m_en[o] = d[0]; m_ref[o] = d[1]; m_scale[o] = (d / 4) % 4; end
        default: ;
      endcase
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < NUM_OBJ; o++) begin
      m_posx[o] = 0; m_gfx[o] = 0; m_col[o] = 0; m_scale[o] = 0;
      m_en[o] = 0; m_ref[o] = 0; l_armed[o] = 0; l_k[o] = -1;
      l_gfx[o] = 0; l_pos[o] = 0; l_hold[o] = 1; l_ref[o] = 0;
    end
    m_status = 0; m_mask = 0; e_color = 0; e_dout = 0;
  endtask

  task automatic model_step();
    bit [NUM_OBJ-1:0] hits = '0;
    int set = 0;
    if (bus.pixel_en && !bus.line_start) begin
      for (int o = 0; o < NUM_OBJ; o++) begin
        if (l_armed[o] && l_k[o] < 0 && int'(bus.hpos) == l_pos[o]) l_k[o] = 0;
        if (l_k[o] >= 0) begin
          int idx = l_k[o] / l_hold[o];
          if (idx < DATA_WIDTH) begin
            int pos = l_ref[o] ? idx : DATA_WIDTH - 1 - idx;
            if (((l_gfx[o] >> pos) % 2 == 1) && m_en[o]) hits[o] = 1'b1;
            l_k[o]++;
          end
        end
      end
    end
    if (bus.pixel_en) begin
      e_color = int'(bus.color_bg);
      for (int o = NUM_OBJ - 1; o >= 0; o--) if (hits[o]) e_color = m_col[o];
    end
    if ($countones(hits) >= 2) set = int'(hits);
    if (bus.enable && !bus.write_enable) e_dout = mread(int'(bus.address));
    if (bus.line_start) begin
      for (int o = 0; o < NUM_OBJ; o++) begin
        l_gfx[o] = m_gfx[o]; l_pos[o] = m_posx[o]; l_ref[o] = m_ref[o];
        l_hold[o] = (m_scale[o] == 0) ? 1 : (m_scale[o] == 1) ? 2 : 4;
        l_armed[o] = m_en[o]; l_k[o] = -1;
      end
    end
    m_clr = 0;
    if (bus.write_enable) mwrite(int'(bus.address), int'(bus.data_in));
    if (COLL) m_status = (m_status & ~m_clr) | set;
  endtask

  // Model update at each edge and one compare shortly after it
  always @(posedge raw_clk or posedge reset) begin
    if (reset) model_reset();
    else model_step();
    #1;
    check("color", 32'(bus.color), e_color);
    check("data_out", 32'(bus.data_out), e_dout);
    check("irq", 32'(bus.collision_irq), ((m_status & m_mask) != 0) ? 1 : 0);
  end

  // ---------------- stimulus helpers ----------------
  int hcur;
  int seen [1024];

  task automatic drive(input bit ls, input bit pe, input bit rd, input bit wr, input int a, input int d);
    @(negedge raw_clk);
    bus.line_start = ls; bus.pixel_en = pe; bus.hpos = hcur[POS_WIDTH-1:0];
    bus.enable = rd; bus.write_enable = wr; bus.address = a[5:0]; bus.data_in = d[7:0];
    @(posedge raw_clk);
    #1;
    bus.line_start = 1'b0; bus.pixel_en = 1'b0; bus.enable = 1'b0; bus.write_enable = 1'b0;
    #1;
    if (pe) begin seen[hcur] = int'(bus.color); hcur++; end
  endtask

  task automatic wr(input int a, input int d); drive(0, 0, 0, 1, a, d); endtask
  task automatic rd(input int a);               drive(0, 0, 1, 0, a, 0); endtask

  task automatic new_line();
    for (int i = 0; i < 1024; i++) seen[i] = -1;
    drive(1, 0, 0, 0, 0, 0);
  endtask

  task automatic sweep(input int lo, input int hi);
    hcur = lo;
    while (hcur <= hi) drive(0, 1, 0, 0, 0, 0);
  endtask

  task automatic cfg(input int o, input int pos, input int gfx, input int col, input int ctrl);
    wr(o * 8 + 0, pos % 256);
    wr(o * 8 + 1, pos / 256);
    wr(o * 8 + 2, gfx);
    wr(o * 8 + 3, col * 2);
    wr(o * 8 + 4, ctrl);
  endtask

  function automatic int hits_in(input int lo, input int hi, input int c);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (seen[i] == c) n++;
    return n;
  endfunction

  localparam int C0 = 'h2A;
  localparam int BG = 'h11;

  initial begin
    reset = 1'b1;
    bus.enable = 0; bus.write_enable = 0; bus.address = '0; bus.data_in = '0;
    bus.hpos = '0; bus.pixel_en = 0; bus.line_start = 0; bus.color_bg = 7'(BG);
    hcur = 0;
    for (int i = 0; i < 1024; i++) seen[i] = -1;

    // Reset state
    repeat (3) @(posedge raw_clk);
    #2;
    check("rst_color", 32'(bus.color), 0);
    check("rst_dout", 32'(bus.data_out), 0);
    check("rst_irq", 32'(bus.collision_irq), 0);
    @(negedge raw_clk) reset = 1'b0;

    // Graphic 0x81 at x=100: pixels 100 and 107 only
    cfg(0, 100, 'h81, C0, 1);
    new_line(); sweep(90, 120);
    check("p100", seen[100], C0);
    check("p107", seen[107], C0);
    check("p99", seen[99], BG);
    check("p101", seen[101], BG);
    check("hits_81", hits_in(90, 120, C0), 2);
    rd(0); check("rd_posx", 32'(bus.data_out), 100);
    rd(3); check("rd_color", 32'(bus.data_out), 'h54);
    rd(4); check("rd_ctrl", 32'(bus.data_out), 1);
    rd(8 * 5); check("rd_absent", 32'(bus.data_out), 0);

    // Reflect, graphic 0x01 at x=50: pixel 50 only
    cfg(0, 50, 'h01, C0, 3);
    new_line(); sweep(40, 70);
    check("refl_p50", seen[50], C0);
    check("refl_hits", hits_in(40, 70, C0), 1);

    // Scale 1 -> 2 pixels, scale 3 -> 4 pixels
    cfg(0, 10, 'h80, C0, 5);
    new_line(); sweep(0, 30);
    check("s1_p11", seen[11], C0);
    check("s1_hits", hits_in(0, 30, C0), 2);
    wr(4, 'h0D);
    new_line(); sweep(0, 30);
    check("s3_p13", seen[13], C0);
    check("s3_p14", seen[14], BG);
    check("s3_hits", hits_in(0, 30, C0), 4);

    // Collision: obj0 and obj2 overlap at 200, obj1 alone at 205
    cfg(0, 200, 'h80, C0, 1);
    cfg(1, 205, 'h80, 'h15, 1);
    cfg(2, 200, 'h80, 'h33, 1);
    wr('h39, 'h05);
    new_line(); sweep(195, 210);
    check("coll_p200", seen[200], C0);
    check("coll_p205", seen[205], 'h15);
    rd('h38);
    check("coll_status", 32'(bus.data_out), COLL ? 5 : 0);
    check("coll_irq", 32'(bus.collision_irq), COLL ? 1 : 0);
    wr('h38, 'h04);
    rd('h38);
    check("coll_w1c", 32'(bus.data_out), COLL ? 1 : 0);
    check("coll_irq2", 32'(bus.collision_irq), COLL ? 1 : 0);
    wr(12, 0); wr(20, 0);

    // Shadow write mid-line waits for the next line
    cfg(0, 20, 'h81, C0, 1);
    new_line(); sweep(15, 22);
    wr(2, 'hFF);
    sweep(23, 35);
    check("mid_p27", seen[27], C0);
    check("mid_hits", hits_in(15, 35, C0), 2);
    new_line(); sweep(15, 35);
    check("next_p28", seen[28], BG);
    check("next_hits", hits_in(15, 35, C0), 8);

    // Reset during SHIFT aborts output at once
    rd(3);
    cfg(0, 30, 'hFF, C0, 1);
    new_line(); sweep(25, 32);
    check("pre_rst_p32", seen[32], C0);
    @(negedge raw_clk) reset = 1'b1;
    #1;
    check("mid_rst_color", 32'(bus.color), 0);
    check("mid_rst_dout", 32'(bus.data_out), 0);
    @(negedge raw_clk) reset = 1'b0;
    cfg(0, 30, 'hFF, C0, 1);
    sweep(25, 40);
    check("post_rst_quiet", hits_in(25, 40, C0), 0);
    new_line(); sweep(25, 40);
    check("post_rst_line", hits_in(25, 40, C0), 8);

    // Randomized lines against the model
    for (int line = 0; line < 12; line++) begin
      bus.color_bg = 7'($urandom);
      for (int o = 0; o < NUM_OBJ; o++) begin
        int pos = ($urandom % 8 == 0) ? 500 : $urandom_range(0, 70);
        int ctl = $urandom_range(0, 15) | (($urandom % 4 != 0) ? 1 : 0);
        cfg(o, pos, $urandom % 256, $urandom % 128, ctl);
      end
      wr('h39, $urandom % 16);
      new_line();
      hcur = 0;
      while (hcur < 80) begin
        int r = $urandom % 100;
        if (r < 15) begin
          int a = ($urandom % 2 != 0) ? $urandom % 40 : $urandom % 64;
          if ($urandom % 2 != 0) wr(a, $urandom % 256);
          else rd(a);
        end else if (r < 30) begin
          drive(0, 0, 0, 0, 0, 0);
        end else begin
          drive(0, 1, 0, 0, 0, 0);
        end
      end
      rd('h38);
    end

    repeat (2) @(posedge raw_clk);
    #3;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
